// File: rtl/traffic_controller.sv
// rtl/traffic_controller.sv - NS/EW light sequencer with emergency preemption
module traffic_controller #(
  parameter int unsigned COUNTER_WIDTH   = 32,
  parameter int unsigned GREEN_TICKS     = 50_000_000,
  parameter int unsigned YELLOW_TICKS    = 10_000_000,
  parameter int unsigned ALLRED_TICKS    = 5_000_000,
  parameter int unsigned EMG_GREEN_TICKS = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emg_ns,
  input  logic       emg_ew,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic [2:0] state_debug
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    EMG_NS    = 3'd6,
    EMG_EW    = 3'd7
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] G_LAST  = COUNTER_WIDTH'(GREEN_TICKS - 1);
  localparam logic [COUNTER_WIDTH-1:0] Y_LAST  = COUNTER_WIDTH'(YELLOW_TICKS - 1);
  localparam logic [COUNTER_WIDTH-1:0] AR_LAST = COUNTER_WIDTH'(ALLRED_TICKS - 1);
  localparam logic [COUNTER_WIDTH-1:0] EG_LAST = COUNTER_WIDTH'(EMG_GREEN_TICKS - 1);
  localparam logic [COUNTER_WIDTH-1:0] ONE     = COUNTER_WIDTH'(1);

  state_t                   state;
  state_t                   nxt;
  logic                     extend;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic                     pend_ns;
  logic                     pend_ew;

  // Decisions use the latched requests so a single-cycle pulse is still honoured.
  always_comb begin
    nxt    = state;
    extend = 1'b0;
    case (state)
      NS_GREEN: begin
        if (pend_ns)                       nxt = EMG_NS;
        else if (pend_ew || cnt == G_LAST) nxt = NS_YELLOW;
      end
      NS_YELLOW: if (cnt == Y_LAST) nxt = ALLRED_A;
      ALLRED_A: begin
        if (cnt == AR_LAST) nxt = pend_ns ? EMG_NS : (pend_ew ? EMG_EW : EW_GREEN);
      end
      EW_GREEN: begin
        if (pend_ew)                       nxt = EMG_EW;
        else if (pend_ns || cnt == G_LAST) nxt = EW_YELLOW;
      end
      EW_YELLOW: if (cnt == Y_LAST) nxt = ALLRED_B;
      ALLRED_B: begin
        if (cnt == AR_LAST) nxt = pend_ns ? EMG_NS : (pend_ew ? EMG_EW : NS_GREEN);
      end
      EMG_NS: begin
        if (cnt == EG_LAST) begin
          if (emg_ns) extend = 1'b1;
          else        nxt    = NS_YELLOW;
        end
      end
      EMG_EW: begin
        if (cnt == EG_LAST) begin
          if (emg_ew) extend = 1'b1;
          else        nxt    = EW_YELLOW;
        end
      end
      default: nxt = NS_GREEN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= NS_GREEN;
      cnt     <= '0;
      pend_ns <= 1'b0;
      pend_ew <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= (nxt != state || extend) ? '0 : cnt + ONE;
      pend_ns <= (state == EMG_NS) ? 1'b0 : (pend_ns | emg_ns);
      pend_ew <= (state == EMG_EW) ? 1'b0 : (pend_ew | emg_ew);
    end
  end

  always_comb begin
    ns_green  = (state == NS_GREEN) || (state == EMG_NS);
    ns_yellow = (state == NS_YELLOW);
    ns_red    = !(ns_green || ns_yellow);
    ew_green  = (state == EW_GREEN) || (state == EMG_EW);
    ew_yellow = (state == EW_YELLOW);
    ew_red    = !(ew_green || ew_yellow);
  end

  assign state_debug = state;

endmodule

// File: tb/tb_traffic_controller.sv
// tb/tb_traffic_controller.sv - scoreboard bench for traffic_controller
module tb_traffic_controller;

  localparam int G  = 50;
  localparam int Y  = 12;
  localparam int AR = 6;
  localparam int EG = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       emg_ns = 1'b0;
  logic       emg_ew = 1'b0;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic [2:0] state_debug;

  traffic_controller #(
    .COUNTER_WIDTH(32), .GREEN_TICKS(G), .YELLOW_TICKS(Y),
    .ALLRED_TICKS(AR), .EMG_GREEN_TICKS(EG)
  ) dut (
    .clk(clk), .rst(rst), .emg_ns(emg_ns), .emg_ew(emg_ew),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .state_debug(state_debug)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  bit running = 0;

  // Reference model: phase name plus cycles remaining in it.
  int m_st;
  int m_left;
  bit m_pns;
  bit m_pew;

  function automatic int dwell(int s);
    case (s)
      0, 3:    return G;
      1, 4:    return Y;
      2, 5:    return AR;
      default: return EG;
    endcase
  endfunction

  // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
  function automatic logic [5:0] lamps_for(int s);
    logic ng, ny, eg, ey;
    ng = (s == 0) || (s == 6);
    ny = (s == 1);
    eg = (s == 3) || (s == 7);
    ey = (s == 4);
    return {!(ng || ny), ny, ng, !(eg || ey), ey, eg};
  endfunction

  task automatic model_reset();
    m_st = 0; m_left = G; m_pns = 0; m_pew = 0;
  endtask

  task automatic model_step(input bit ens, input bit eew);
    int nx;
    bit restart;
    bit done;
    nx = m_st; restart = 0; done = (m_left == 1);
    case (m_st)
      0: if (m_pns) nx = 6; else if (m_pew || done) nx = 1;
      1: if (done) nx = 2;
      2: if (done) nx = m_pns ? 6 : (m_pew ? 7 : 3);
      3: if (m_pew) nx = 7; else if (m_pns || done) nx = 4;
      4: if (done) nx = 5;
      5: if (done) nx = m_pns ? 6 : (m_pew ? 7 : 0);
      6: if (done) begin if (ens) restart = 1; else nx = 1; end
      default: if (done) begin if (eew) restart = 1; else nx = 4; end
    endcase
    m_pns = (m_st == 6) ? 1'b0 : (m_pns | ens);
    m_pew = (m_st == 7) ? 1'b0 : (m_pew | eew);
    m_left = (nx != m_st || restart) ? dwell(nx) : m_left - 1;
    m_st = nx;
  endtask

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit ens, input bit eew);
    emg_ns = ens;
    emg_ew = eew;
    model_step(ens, eew);
    exp_q.push_back(m_st);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_state", state_debug, 0);
    check("rst_lamps", {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}, 6'b001100);
  endtask

  task automatic do_reset();
    emg_ns = 0; emg_ew = 0;
    rst = 1;
    #1;
    check_reset_outputs();
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_model(input int target, input int budget);
    int n;
    n = 0;
    while (m_st != target && n < budget) begin
      step(0, 0);
      n++;
    end
    total++;
    if (m_st != target) begin
      bad++;
      $display("FAIL wait_state: state %0d not reached in %0d cycles", target, budget);
    end
  endtask

  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && running) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty: no expected entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("state", state_debug, e);
          check("lamps", {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}, lamps_for(e));
          check("ns_one_lamp", $countones({ns_red, ns_yellow, ns_green}), 1);
          check("ew_one_lamp", $countones({ew_red, ew_yellow, ew_green}), 1);
          check("both_green", ns_green & ew_green, 0);
          check("green_vs_yellow", (ns_green & ew_yellow) | (ew_green & ns_yellow), 0);
        end
      end
    end
  end

  initial begin
    int first_ew;
    int ret_ns;
    int hold_ns;
    int hold_ew;
    bit ens;
    bit eew;
    model_reset();
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst = 0;
    running = 1;

    first_ew = -1;
    ret_ns = -1;
    for (int n = 1; n <= 140; n++) begin
      step(0, 0);
      if (state_debug == 3'd3 && first_ew < 0) first_ew = n;
      if (state_debug == 3'd0 && first_ew > 0 && ret_ns < 0) ret_ns = n;
    end
    check("ew_green_start", first_ew, 68);
    check("allred_b_end", ret_ns, 136);

    // EW request held mid NS green
    do_reset();
    idle(20);
    for (int i = 0; i < 15; i++) step(0, 1);
    idle(200);

    // single-cycle NS pulse during EW yellow
    wait_model(4, 300);
    step(1, 0);
    idle(150);

    // NS request held, forcing extensions
    wait_model(0, 400);
    for (int i = 0; i < 200; i++) step(1, 0);
    idle(150);

    // simultaneous requests during all-red
    wait_model(2, 400);
    step(1, 1);
    idle(300);

    hold_ns = 0;
    hold_ew = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      if (hold_ns > 0) begin ens = 1; hold_ns--; end
      else begin ens = ($urandom_range(0, 149) == 0); if (ens) hold_ns = $urandom_range(0, 120); end
      if (hold_ew > 0) begin eew = 1; hold_ew--; end
      else begin eew = ($urandom_range(0, 149) == 0); if (eew) hold_ew = $urandom_range(0, 120); end
      step(ens, eew);
    end

    running = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
